lut_sweep_eval: RTL and testbench

- Parametrised, registered truth-table engine for the digital-design labs.
- Holds a 2^N_IN-entry single-bit function table, programmable at runtime. Offers a 1-cycle direct-evaluation path.
- Runs a self-timed exhaustive sweep of all input combinations. Streams (input, output) pairs and reports the minterm count, replacing hand-written exhaustive testbench loops.

---
 rtl/lut_sweep_eval.sv | 233 +++++++++++++++++++++++
 tb/tb_lut_sweep_eval.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lut_sweep_eval.sv
// rtl/lut_sweep_eval.sv - registered truth-table engine with direct evaluation and exhaustive sweep
//
// Purpose:
//   Holds a DEPTH = 2^N_IN entry single-bit function table that can be rewritten
//   at runtime. It offers two ways to read it:
//     - a 1-cycle registered direct evaluation (eval_in -> eval_y);
//     - a self-timed sweep that streams every (input, output) pair and counts
//       the minterms (entries with f=1) along the way.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   cfg_we    table write strobe; accepted only while idle
//   cfg_addr  table entry to write
//   cfg_bit   value written to table[cfg_addr]
//   cfg_err   one-cycle pulse: a write arrived while busy and was dropped
//   eval_in   direct-evaluation input vector (MSB = variable A)
//   eval_y    registered table[eval_in]
//   start     begin a sweep (level, sampled every cycle while idle)
//   abort     cancel a running sweep; wins over completion and start
//   busy      high while sweeping and during the done cycle
//   sw_valid  sw_in/sw_y carry a swept pair this cycle
//   sw_in     current swept input vector (holds when sw_valid=0)
//   sw_y      table[sw_in] (holds when sw_valid=0)
//   ones_cnt  number of swept entries with f=1; holds until the next start
//   done      one-cycle pulse when a sweep completes
//   hit       (LUT_SWEEP_FIRST_HIT_EN only) sweep stopped on an f=1 entry
//   hit_in    (LUT_SWEEP_FIRST_HIT_EN only) index of that entry
//
// Build option:
//   LUT_SWEEP_FIRST_HIT_EN - when defined, a sweep stops at the first entry
//   with f=1 and reports it on hit/hit_in. When undefined, every sweep covers
//   all DEPTH entries and the hit ports do not exist.

module lut_sweep_eval #(
  parameter int                    N_IN = 4,
  parameter logic [(1<<N_IN)-1:0]  INIT = 16'h38F0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [N_IN-1:0]   cfg_addr,
  input  logic              cfg_bit,
  output logic              cfg_err,
  input  logic [N_IN-1:0]   eval_in,
  output logic              eval_y,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              sw_valid,
  output logic [N_IN-1:0]   sw_in,
  output logic              sw_y,
  output logic [N_IN:0]     ones_cnt,
  output logic              done
`ifdef LUT_SWEEP_FIRST_HIT_EN
  ,
  output logic              hit,
  output logic [N_IN-1:0]   hit_in
`endif
);

  localparam int              DEPTH    = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q,    state_d;
  logic [DEPTH-1:0]  table_q,    table_d;
  logic              cfg_err_q,  cfg_err_d;
  logic              eval_y_q,   eval_y_d;
  logic              busy_q,     busy_d;
  logic              sw_valid_q, sw_valid_d;
  logic [N_IN-1:0]   sw_in_q,    sw_in_d;
  logic              sw_y_q,     sw_y_d;
  logic [N_IN:0]     ones_cnt_q, ones_cnt_d;
  logic              done_q,     done_d;
`ifdef LUT_SWEEP_FIRST_HIT_EN
  logic              hit_q,      hit_d;
  logic [N_IN-1:0]   hit_in_q,   hit_in_d;
`endif

  // sw_in_q doubles as the sweep index: it always names the entry currently
  // on the stream, so the next entry is sw_in_q + 1.
  logic [N_IN-1:0] nxt_idx;
  logic            nxt_bit;
  logic            sweep_stop;

  always_comb begin
    nxt_idx = sw_in_q + 1'b1;
    nxt_bit = table_q[nxt_idx];
`ifdef LUT_SWEEP_FIRST_HIT_EN
    // The entry on the stream now is the last one if it is a hit.
    sweep_stop = (sw_in_q == LAST_IDX) || sw_y_q;
`else
    sweep_stop = (sw_in_q == LAST_IDX);
`endif
  end

  always_comb begin
    state_d    = state_q;
    table_d    = table_q;
    cfg_err_d  = 1'b0;
    busy_d     = busy_q;
    sw_valid_d = sw_valid_q;
    sw_in_d    = sw_in_q;
    sw_y_d     = sw_y_q;
    ones_cnt_d = ones_cnt_q;
    done_d     = 1'b0;
`ifdef LUT_SWEEP_FIRST_HIT_EN
    hit_d      = hit_q;
    hit_in_d   = hit_in_q;
`endif

    // Read uses the current table, so a same-cycle write to the same
    // address is seen one cycle later (read-before-write).
    eval_y_d = table_q[eval_in];

    // The table is frozen while a sweep is in flight so the stream and the
    // count always describe one consistent function.
    if (cfg_we) begin
      if (state_q == S_IDLE) begin
        table_d[cfg_addr] = cfg_bit;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_SWEEP;
          busy_d     = 1'b1;
          sw_valid_d = 1'b1;
          sw_in_d    = '0;
          sw_y_d     = table_q[0];
          ones_cnt_d = {{N_IN{1'b0}}, table_q[0]};
`ifdef LUT_SWEEP_FIRST_HIT_EN
          hit_d      = 1'b0;
          hit_in_d   = '0;
`endif
        end
      end

      S_SWEEP: begin
        if (abort) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          sw_valid_d = 1'b0;
          ones_cnt_d = '0;
        end else if (sweep_stop) begin
          state_d    = S_DONE;
          sw_valid_d = 1'b0;
          done_d     = 1'b1;
`ifdef LUT_SWEEP_FIRST_HIT_EN
          hit_d      = sw_y_q;
          hit_in_d   = sw_y_q ? sw_in_q : '0;
`endif
        end else begin
          sw_in_d    = nxt_idx;
          sw_y_d     = nxt_bit;
          ones_cnt_d = ones_cnt_q + {{N_IN{1'b0}}, nxt_bit};
        end
      end

      S_DONE: begin
        // start is not looked at here; a held start is picked up from IDLE.
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (abort) begin
          ones_cnt_d = '0;
        end
      end

      default: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        sw_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      table_q    <= INIT;
      cfg_err_q  <= 1'b0;
      eval_y_q   <= 1'b0;
      busy_q     <= 1'b0;
      sw_valid_q <= 1'b0;
      sw_in_q    <= '0;
      sw_y_q     <= 1'b0;
      ones_cnt_q <= '0;
      done_q     <= 1'b0;
`ifdef LUT_SWEEP_FIRST_HIT_EN
      hit_q      <= 1'b0;
      hit_in_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      table_q    <= table_d;
      cfg_err_q  <= cfg_err_d;
      eval_y_q   <= eval_y_d;
      busy_q     <= busy_d;
      sw_valid_q <= sw_valid_d;
      sw_in_q    <= sw_in_d;
      sw_y_q     <= sw_y_d;
      ones_cnt_q <= ones_cnt_d;
      done_q     <= done_d;
`ifdef LUT_SWEEP_FIRST_HIT_EN
      hit_q      <= hit_d;
      hit_in_q   <= hit_in_d;
`endif
    end
  end

  assign cfg_err  = cfg_err_q;
  assign eval_y   = eval_y_q;
  assign busy     = busy_q;
  assign sw_valid = sw_valid_q;
  assign sw_in    = sw_in_q;
  assign sw_y     = sw_y_q;
  assign ones_cnt = ones_cnt_q;
  assign done     = done_q;
`ifdef LUT_SWEEP_FIRST_HIT_EN
  assign hit      = hit_q;
  assign hit_in   = hit_in_q;
`endif

endmodule

// File: tb/tb_lut_sweep_eval.sv
// tb/tb_lut_sweep_eval.sv - directed self-checking bench for lut_sweep_eval
module tb_lut_sweep_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cfg_we, cfg_bit, cfg_err, eval_y, start, abort;
  logic       busy, sw_valid, sw_y, done;
  logic [3:0] cfg_addr, eval_in, sw_in;
  logic [4:0] ones_cnt;

  logic       cfg_we2, cfg_bit2, cfg_err2, eval_y2, start2, abort2;
  logic       busy2, sw_valid2, sw_y2, done2;
  logic [1:0] cfg_addr2, eval_in2, sw_in2;
  logic [2:0] ones_cnt2;

`ifdef LUT_SWEEP_FIRST_HIT_EN
  logic       hit, hit2;
  logic [3:0] hit_in;
  logic [1:0] hit_in2;
`endif

  lut_sweep_eval u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bit(cfg_bit), .cfg_err(cfg_err),
    .eval_in(eval_in), .eval_y(eval_y),
    .start(start), .abort(abort), .busy(busy),
    .sw_valid(sw_valid), .sw_in(sw_in), .sw_y(sw_y),
    .ones_cnt(ones_cnt), .done(done)
`ifdef LUT_SWEEP_FIRST_HIT_EN
    , .hit(hit), .hit_in(hit_in)
`endif
  );

  lut_sweep_eval #(.N_IN(2), .INIT(4'hF)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we2), .cfg_addr(cfg_addr2), .cfg_bit(cfg_bit2), .cfg_err(cfg_err2),
    .eval_in(eval_in2), .eval_y(eval_y2),
    .start(start2), .abort(abort2), .busy(busy2),
    .sw_valid(sw_valid2), .sw_in(sw_in2), .sw_y(sw_y2),
    .ones_cnt(ones_cnt2), .done(done2)
`ifdef LUT_SWEEP_FIRST_HIT_EN
    , .hit(hit2), .hit_in(hit_in2)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full sweep; tbl is the hand-written table contents, exp_ones its minterm count.
  task automatic sweep(input logic [15:0] tbl, input int exp_ones, input bit poke);
    int cnt;
    cnt = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int j = 0; j < 16; j++) begin
      cnt += int'(tbl[j]);
      chk("sw_valid", sw_valid, 1);
      chk("sw_in", sw_in, j);
      chk("sw_y", sw_y, tbl[j]);
      chk("busy_sweep", busy, 1);
      chk("done_early", done, 0);
      chk("ones_running", ones_cnt, cnt);
      if (poke) begin
        if (j == 4) begin cfg_we = 1'b1; cfg_addr = 4'd5; cfg_bit = 1'b0; end
        if (j == 5) begin chk("cfg_err_pulse", cfg_err, 1); cfg_we = 1'b0; start = 1'b1; end
        if (j == 6) begin chk("cfg_err_clear", cfg_err, 0); start = 1'b0; end
      end
      tick;
    end
    chk("done_pulse", done, 1);
    chk("sw_valid_done", sw_valid, 0);
    chk("busy_done", busy, 1);
    chk("ones_final", ones_cnt, exp_ones);
    tick;
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    chk("ones_hold", ones_cnt, exp_ones);
  endtask

  logic [15:0] f_ref;

  initial begin
    f_ref  = 16'h38F0;
    rst_n  = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_bit = 1'b0; eval_in = '0; start = 1'b0; abort = 1'b0;
    cfg_we2 = 1'b0; cfg_addr2 = '0; cfg_bit2 = 1'b0; eval_in2 = '0; start2 = 1'b0; abort2 = 1'b0;
    repeat (2) tick;

    chk("rst_eval_y", eval_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sw_valid", sw_valid, 0);
    chk("rst_sw_in", sw_in, 0);
    chk("rst_sw_y", sw_y, 0);
    chk("rst_ones", ones_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);

    rst_n = 1'b1;
    tick;

    // Direct evaluation of the default function, one cycle latency.
    for (int i = 0; i < 16; i++) begin
      eval_in = 4'(i);
      tick;
      chk("eval_default", eval_y, f_ref[i]);
    end

    // Full sweep with a busy write and a busy start injected.
    sweep(16'h38F0, 7, 1'b1);
    eval_in = 4'd5;
    tick;
    chk("table_unchanged", eval_y, 1);

    // Idle writes, including a read-before-write on entry 13.
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_bit = 1'b1;
    tick;
    cfg_addr = 4'd13; cfg_bit = 1'b0; eval_in = 4'd13;
    tick;
    chk("rbw_old", eval_y, 1);
    cfg_we = 1'b0;
    tick;
    chk("rbw_new", eval_y, 0);
    chk("idle_write_no_err", cfg_err, 0);
    sweep(16'h18F1, 7, 1'b0);

    // Abort on the third valid cycle.
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("abort_sw_in0", sw_in, 0);
    tick;
    tick;
    chk("abort_sw_in2", sw_in, 2);
    chk("abort_pre_ones", ones_cnt, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_sw_valid", sw_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ones", ones_cnt, 0);
    chk("abort_sw_in_hold", sw_in, 2);
    tick;
    chk("abort_no_late_done", done, 0);

    // Asynchronous reset in the middle of a sweep.
    eval_in = 4'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("pre_rst_eval_y", eval_y, 1);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_sw_valid", sw_valid, 0);
    chk("midrst_sw_in", sw_in, 0);
    chk("midrst_ones", ones_cnt, 0);
    chk("midrst_eval_y", eval_y, 0);
    chk("midrst_done", done, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("init_restored_0", eval_y, 0);
    eval_in = 4'd13;
    tick;
    chk("init_restored_13", eval_y, 1);
    chk("post_rst_done", done, 0);

    // Narrow instance with an all-ones table: count reaches DEPTH.
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("n2_sw_valid", sw_valid2, 1);
      chk("n2_sw_in", sw_in2, j);
      tick;
    end
    chk("n2_done", done2, 1);
    chk("n2_ones", ones_cnt2, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
